// File: rtl/snake_score_ctrl_pkg.sv
// Shared types and constants for the snake score controller: state encoding, BCD widths
// and the saturating 2-digit BCD increment shared by the counter and the high-score compare.
package snake_score_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int          BCD_W     = 4;
    localparam logic [7:0]  SCORE_MAX = 8'h99;

    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == SCORE_MAX) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that saturates at 99; clear has priority over increment.
module bcd2_counter
    import snake_score_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] d1,
    output logic [BCD_W-1:0] d0
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 <= '0;
            d0 <= '0;
        end else if (clr) begin
            d1 <= '0;
            d0 <= '0;
        end else if (inc) begin
            {d1, d0} <= bcd2_inc({d1, d0});
        end
    end

endmodule

// File: rtl/snake_score_ctrl.sv
// Game-state and score keeper for the snake game: play/over sequencing, BCD score,
// session high score and a post-game hold window during which restart is locked out.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  ST_IDLE | after reset, waiting for first start rise
//  ST_PLAY | game running, eat increments score, crash ends the game
//  ST_OVER | game ended, score frozen, restart allowed once hold expires
module snake_score_ctrl
    import snake_score_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int HOLD_W      = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             eat,
    input  logic             crash,
    output logic [BCD_W-1:0] score1,
    output logic [BCD_W-1:0] score0,
    output logic [BCD_W-1:0] high1,
    output logic [BCD_W-1:0] high0,
    output logic             g_over,
    output logic             playing,
    output logic             new_high
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    state_t            state;
    logic              start_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              start_rise;
    logic              hold_done;
    logic              score_clr;
    logic              score_inc;
    logic [7:0]        score_final;

    assign start_rise = start & ~start_q;
    assign hold_done  = (hold_cnt == '0);
    assign score_clr  = start_rise &&
                        ((state == ST_IDLE) || ((state == ST_OVER) && hold_done));
    assign score_inc  = (state == ST_PLAY) && eat;

    // A same-cycle eat lands in the counter at this edge, so the high-score
    // compare must see the already-incremented value.
    assign score_final = eat ? bcd2_inc({score1, score0}) : {score1, score0};

    bcd2_counter u_score (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (score_clr),
        .inc   (score_inc),
        .d1    (score1),
        .d0    (score0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            start_q  <= 1'b0;
            hold_cnt <= '0;
            high1    <= '0;
            high0    <= '0;
            new_high <= 1'b0;
        end else begin
            start_q  <= start;
            new_high <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_rise) state <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (crash) begin
                        state    <= ST_OVER;
                        hold_cnt <= HOLD_LOAD;
                        if (score_final > {high1, high0}) begin
                            {high1, high0} <= score_final;
                            new_high       <= 1'b1;
                        end
                    end
                end
                ST_OVER: begin
                    if (!hold_done) begin
                        hold_cnt <= hold_cnt - HOLD_ONE;
                    end else if (start_rise) begin
                        state <= ST_PLAY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign playing = (state == ST_PLAY);
    assign g_over  = (state == ST_OVER);

endmodule

// File: tb/tb_snake_score_ctrl.sv
// Directed-vector bench for snake_score_ctrl with a short hold window (8 cycles).
module tb_snake_score_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       eat;
    logic       crash;
    logic [3:0] score1;
    logic [3:0] score0;
    logic [3:0] high1;
    logic [3:0] high0;
    logic       g_over;
    logic       playing;
    logic       new_high;

    int n_chk;
    int n_fail;

    snake_score_ctrl #(
        .HOLD_CYCLES (8),
        .HOLD_W      (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .eat      (eat),
        .crash    (crash),
        .score1   (score1),
        .score0   (score0),
        .high1    (high1),
        .high0    (high0),
        .g_over   (g_over),
        .playing  (playing),
        .new_high (new_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic eat_n(input int n);
        for (int i = 0; i < n; i++) begin
            eat = 1'b1;
            tick();
        end
        eat = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic crash_now(input logic with_eat);
        crash = 1'b1;
        eat   = with_eat;
        tick();
        crash = 1'b0;
        eat   = 1'b0;
    endtask

    task automatic check_score(input string tag, input logic [7:0] exp);
        check_val(tag, {24'd0, score1, score0}, {24'd0, exp});
    endtask

    task automatic check_high(input string tag, input logic [7:0] exp);
        check_val(tag, {24'd0, high1, high0}, {24'd0, exp});
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        eat    = 1'b0;
        crash  = 1'b0;
        tick();
        check_score("rst_score", 8'h00);
        check_high("rst_high", 8'h00);
        check_val("rst_flags", {29'd0, g_over, playing, new_high}, 32'd0);
        rst_n = 1'b1;
        tick();

        // IDLE ignores eat and crash
        eat_n(3);
        crash_now(1'b0);
        check_score("idle_eat_ignored", 8'h00);
        check_val("idle_state", {30'd0, g_over, playing}, 32'd0);

        start_pulse();
        check_val("play_after_start", {30'd0, g_over, playing}, 32'd1);
        eat_n(9);
        check_score("score_09", 8'h09);
        eat_n(1);
        check_score("carry_10", 8'h10);
        eat_n(2);
        check_score("score_12", 8'h12);
        eat_n(87);
        check_score("score_99", 8'h99);
        eat_n(6);
        check_score("sat_99", 8'h99);
        crash_now(1'b0);
        check_val("over_flags", {30'd0, g_over, playing}, 32'd2);
        check_high("high_99", 8'h99);
        check_val("new_high_99", {31'd0, new_high}, 32'd1);
        tick();
        check_val("new_high_1cyc", {31'd0, new_high}, 32'd0);
        check_score("frozen_99", 8'h99);

        // Hold window: crash edge was edge 0, now one tick past edge 1.
        tick();
        start = 1'b1;
        tick();
        check_val("early_start_ignored", {30'd0, g_over, playing}, 32'd2);
        start = 1'b0;
        eat   = 1'b1;
        tick();
        eat   = 1'b0;
        check_score("over_eat_ignored", 8'h99);
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("late_start_play", {30'd0, g_over, playing}, 32'd1);
        check_score("restart_cleared", 8'h00);

        // start held from cycle 3 across hold expiry must not restart
        crash_now(1'b0);
        check_val("zero_score_no_high", {31'd0, new_high}, 32'd0);
        tick();
        tick();
        start = 1'b1;
        repeat (13) tick();
        check_val("held_start_no_restart", {30'd0, g_over, playing}, 32'd2);
        start = 1'b0;
        tick();
        start_pulse();
        check_val("fresh_rise_restart", {30'd0, g_over, playing}, 32'd1);

        // asynchronous reset mid-game
        eat_n(37);
        check_score("score_37", 8'h37);
        #2;
        rst_n = 1'b0;
        #1;
        check_score("async_rst_score", 8'h00);
        check_high("async_rst_high", 8'h00);
        check_val("async_rst_flags", {29'd0, g_over, playing, new_high}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // equal score does not update high
        start_pulse();
        eat_n(15);
        crash_now(1'b0);
        check_high("game_a_high", 8'h15);
        check_val("game_a_pulse", {31'd0, new_high}, 32'd1);
        repeat (8) tick();
        start_pulse();
        eat_n(15);
        crash_now(1'b0);
        check_high("game_b_high", 8'h15);
        check_val("game_b_no_pulse", {31'd0, new_high}, 32'd0);
        repeat (8) tick();
        start_pulse();
        eat_n(16);
        crash_now(1'b0);
        check_high("game_c_high", 8'h16);
        check_val("game_c_pulse", {31'd0, new_high}, 32'd1);

        // eat and crash in the same cycle
        repeat (8) tick();
        start_pulse();
        eat_n(41);
        check_score("score_41", 8'h41);
        crash_now(1'b1);
        check_score("eat_crash_score", 8'h42);
        check_val("eat_crash_over", {30'd0, g_over, playing}, 32'd2);
        check_high("eat_crash_high", 8'h42);
        check_val("eat_crash_pulse", {31'd0, new_high}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
